scalar_writeback_ctrl: RTL and testbench
========================================

Name: scalar_writeback_ctrl

Overview:
Write-side initiator for the scalar register file (16 x 32-bit, 3 read / 1 write port). Accepts writeback requests from two producers, ALU and memory, over valid/ready handshakes. Arbitrates between them round-robin and buffers requests in a small in-order FIFO. Drives the register file write port (RD, WD, wr_enable) at most one write per cycle, and exports a pending-write scoreboard for hazard detection.

Parameters:
DATA_W, 32, register data width
ADDR_W, 4, register index width (16 registers)
DEPTH, 4, FIFO entries; must be a power of two, at least 2

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU writeback request valid
alu_rd  in  ADDR_W  ALU destination register
alu_wd  in  DATA_W  ALU write data
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  memory writeback request valid
mem_rd  in  ADDR_W  memory destination register
mem_wd  in  DATA_W  memory write data
mem_ready  out  1  memory request accepted this cycle
hold  in  1  suppresses issue to the register file; enqueue continues
RD  out  ADDR_W  register file write address
WD  out  DATA_W  register file write data
wr_enable  out  1  register file write strobe
pending  out  2**ADDR_W  bit i=1 while any buffered entry targets register i
fifo_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, async): FIFO pointers, count and all entry storage cleared. last_grant=MEM. Outputs go immediately to wr_enable=0, RD=0, WD=0, pending=0, fifo_count=0. Buffered requests are discarded, not written.
- can_push = (count<DEPTH) || pop. A full FIFO still accepts when a pop happens in the same cycle.
- Arbitration is combinational, one grant per cycle:
  - Only one source valid: that source is granted.
  - Both valid: the source not granted last time is granted.
  - last_grant updates only on an actual acceptance.
- alu_ready = grant_alu && can_push; mem_ready = grant_mem && can_push. Acceptance = valid && ready.
- ready is asserted only to the granted source. Producers hold valid and payload stable until accepted.
- Issue: wr_enable = (count!=0) && !hold. RD and WD are the FIFO head, or 0 when empty. pop = wr_enable. The register file commits at the same rising edge as the pop.
- Latency: a request accepted at edge N appears on wr_enable/RD/WD during cycle N+1 (hold=0, FIFO previously empty) and commits at edge N+1. There is no empty bypass.
- Ordering: strict FIFO order. Two writes to the same register commit in acceptance order; the last one wins.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- pending is the OR over valid entries of decode(entry.rd). A popping entry still shows in pending during its issue cycle.
- All ADDR_W indices, including 0, are written normally. There is no special zero register.
- hold=1 with a full FIFO: both ready=0, wr_enable=0, and state is frozen.

Decomposition:
- Package scalar_wb_pkg:
  - constants DATA_W=32, ADDR_W=4, NUM_REGS=16
  - typedef wb_entry_t packed struct {rd[ADDR_W], wd[DATA_W]}
  - enum src_t {SRC_ALU, SRC_MEM}
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_entry_t with push, pop, head, count, a per-entry valid vector for the scoreboard, and async active-low reset.
- The top level holds the arbiter, last_grant flop and scoreboard decode.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with alu_valid=1 -> wr_enable=0, RD=0, WD=0, pending=0, fifo_count=0. After release, alu_ready=1 in the first cycle.
2. Single write: alu rd=3 wd=99 accepted at edge N -> cycle N+1 shows wr_enable=1, RD=3, WD=99, pending[3]=1. From cycle N+2, wr_enable=0, pending=0, and a readback of r3 gives 99.
3. Contention: alu (rd=4, wd=50) and mem (rd=5, wd=255) both valid after reset -> ALU granted first, mem_ready=0; MEM granted next cycle. Writes issue as r4=50, then r5=255. Alternation continues with persistent contention.
4. Full/hold: hold=1, push 4 ALU entries (rd 1..4) -> fifo_count=4, both ready=0, wr_enable=0, pending=0x001E. Release hold with mem rd=6 valid -> mem accepted in the first release cycle (full+pop), and writes occur r1,r2,r3,r4,r6 on consecutive cycles.
5. Same register: alu rd=3 wd=2, then rd=3 wd=7 -> pending[3] stays 1 until the second write issues. r3 ends at 7.
6. Reset mid-operation: 3 entries buffered with hold=1, assert rst asynchronously mid-cycle -> fifo_count=0 and pending=0 immediately. After release, with hold=0, no stale write is issued.

Source files
------------

// File: rtl/scalar_wb_pkg.sv
// Shared types and sizes for the scalar register file writeback path.
package scalar_wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback buffer; exposes every slot plus its valid bit so the
// parent can build a pending-write scoreboard without extra state.
module wb_fifo
    import scalar_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  wb_entry_t                  din_i,
    input  logic                       pop_i,
    output wb_entry_t                  head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DEPTH-1:0]           vld_o,
    output wb_entry_t [DEPTH-1:0]      entries_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]      vld_q;
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [CNT_W-1:0]      cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            vld_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (pop_i) begin
                vld_q[rptr_q] <= 1'b0;
                rptr_q        <= rptr_q + PTR_W'(1);
            end
            // Push after pop: when full, the slot being vacated is refilled.
            if (push_i) begin
                mem_q[wptr_q] <= din_i;
                vld_q[wptr_q] <= 1'b1;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_o    = mem_q[rptr_q];
    assign count_o   = cnt_q;
    assign vld_o     = vld_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/scalar_writeback_ctrl.sv
// Write-port initiator for the scalar register file: round-robin ALU/MEM
// arbitration into an in-order FIFO, one write per cycle, pending scoreboard.
module scalar_writeback_ctrl
    import scalar_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_wd,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]        mem_wd,
    output logic                     mem_ready,
    input  logic                     hold,
    output logic [ADDR_W-1:0]        RD,
    output logic [DATA_W-1:0]        WD,
    output logic                     wr_enable,
    output logic [NUM_REGS-1:0]      pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    src_t                  last_grant_q, last_grant_d;
    logic                  grant_alu, grant_mem;
    logic                  can_push, push, pop, nonempty;
    wb_entry_t             din, head;
    logic [DEPTH-1:0]      ent_vld;
    wb_entry_t [DEPTH-1:0] entries;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_grant_q <= SRC_MEM;
        else      last_grant_q <= last_grant_d;
    end

    always_comb begin
        nonempty     = (fifo_count != '0);
        pop          = nonempty && !hold;
        can_push     = (fifo_count < FULL_CNT) || pop;
        // Under contention the source that lost last time wins.
        grant_alu    = alu_valid && (!mem_valid || last_grant_q == SRC_MEM);
        grant_mem    = mem_valid && (!alu_valid || last_grant_q == SRC_ALU);
        alu_ready    = grant_alu && can_push;
        mem_ready    = grant_mem && can_push;
        push         = (alu_valid && alu_ready) || (mem_valid && mem_ready);
        last_grant_d = last_grant_q;
        din          = '{rd: mem_rd, wd: mem_wd};
        if (alu_valid && alu_ready) begin
            last_grant_d = SRC_ALU;
            din          = '{rd: alu_rd, wd: alu_wd};
        end else if (mem_valid && mem_ready) begin
            last_grant_d = SRC_MEM;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .push_i    (push),
        .din_i     (din),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (fifo_count),
        .vld_o     (ent_vld),
        .entries_o (entries)
    );

    assign wr_enable = pop;
    assign RD        = nonempty ? head.rd : '0;
    assign WD        = nonempty ? head.wd : '0;

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) pending[entries[i].rd] = 1'b1;
        end
    end

endmodule

// File: tb/tb_scalar_writeback_ctrl.sv
// Directed bench for scalar_writeback_ctrl with a register file model.
module tb_scalar_writeback_ctrl;

    logic        clk, rst;
    logic        alu_valid, mem_valid, hold;
    logic [3:0]  alu_rd, mem_rd, RD;
    logic [31:0] alu_wd, mem_wd, WD;
    logic        alu_ready, mem_ready, wr_enable;
    logic [15:0] pending;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] rf [16];
    logic [35:0] wlog [$];
    logic [35:0] exp3 [4];
    logic [35:0] exp4 [5];

    scalar_writeback_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wd(mem_wd), .mem_ready(mem_ready),
        .hold(hold), .RD(RD), .WD(WD), .wr_enable(wr_enable),
        .pending(pending), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: a write seen mid-cycle commits at the next rising edge.
    always @(negedge clk) begin
        if (rst && wr_enable) begin
            rf[RD] = WD;
            wlog.push_back({RD, WD});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = '0;
        exp3 = '{{4'd4, 32'd50}, {4'd5, 32'd255}, {4'd7, 32'd11}, {4'd8, 32'd22}};
        exp4 = '{{4'd1, 32'd101}, {4'd2, 32'd102}, {4'd3, 32'd103}, {4'd4, 32'd104}, {4'd6, 32'd66}};
        rst = 1'b0; hold = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd3; alu_wd = 32'd99;
        mem_valid = 1'b0; mem_rd = '0; mem_wd = '0;

        // 1. reset with a valid request outstanding
        tick(); tick();
        chk("rst_wr_en", wr_enable, 0);
        chk("rst_rd", RD, 0);
        chk("rst_wd", WD, 0);
        chk("rst_pending", pending, 0);
        chk("rst_count", fifo_count, 0);
        tick();
        rst = 1'b1;
        #1 chk("rel_alu_ready", alu_ready, 1);

        // 2. single write, one-cycle latency
        tick();
        alu_valid = 1'b0;
        #1;
        chk("t2_wr_en", wr_enable, 1);
        chk("t2_rd", RD, 3);
        chk("t2_wd", WD, 99);
        chk("t2_pending", pending, 16'h0008);
        chk("t2_count", fifo_count, 1);
        tick();
        chk("t2_idle_wr_en", wr_enable, 0);
        chk("t2_idle_pending", pending, 0);
        chk("t2_idle_count", fifo_count, 0);
        chk("t2_r3", rf[3], 99);

        // 3. contention alternates, starting with ALU after reset
        rst = 1'b0;
        #1 tick();
        rst = 1'b1;
        wlog.delete();
        alu_valid = 1'b1; alu_rd = 4'd4; alu_wd = 32'd50;
        mem_valid = 1'b1; mem_rd = 4'd5; mem_wd = 32'd255;
        #1;
        chk("t3_c1_alu_ready", alu_ready, 1);
        chk("t3_c1_mem_ready", mem_ready, 0);
        tick();
        alu_rd = 4'd7; alu_wd = 32'd11;
        #1;
        chk("t3_c2_alu_ready", alu_ready, 0);
        chk("t3_c2_mem_ready", mem_ready, 1);
        chk("t3_c2_rd", RD, 4);
        chk("t3_c2_wd", WD, 50);
        tick();
        mem_rd = 4'd8; mem_wd = 32'd22;
        #1;
        chk("t3_c3_alu_ready", alu_ready, 1);
        chk("t3_c3_mem_ready", mem_ready, 0);
        chk("t3_c3_rd", RD, 5);
        tick();
        alu_valid = 1'b0;
        #1;
        chk("t3_c4_mem_ready", mem_ready, 1);
        chk("t3_c4_rd", RD, 7);
        tick();
        mem_valid = 1'b0;
        #1 chk("t3_c5_wd", WD, 22);
        tick();
        chk("t3_idle_wr_en", wr_enable, 0);
        chk("t3_log_len", wlog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_log%0d", i), (i < wlog.size()) ? wlog[i] : '1, exp3[i]);

        // 4. fill under hold, then release with full+pop acceptance
        wlog.delete();
        hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            alu_valid = 1'b1; alu_rd = 4'(k); alu_wd = 32'(100 + k);
            #1 chk($sformatf("t4_push%0d_ready", k), alu_ready, 1);
            tick();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 4'd6; mem_wd = 32'd66;
        #1;
        chk("t4_full_count", fifo_count, 4);
        chk("t4_full_alu_ready", alu_ready, 0);
        chk("t4_full_mem_ready", mem_ready, 0);
        chk("t4_full_wr_en", wr_enable, 0);
        chk("t4_full_pending", pending, 16'h001E);
        tick();
        chk("t4_frozen_count", fifo_count, 4);
        chk("t4_frozen_mem_ready", mem_ready, 0);
        hold = 1'b0;
        #1;
        chk("t4_rel_mem_ready", mem_ready, 1);
        chk("t4_rel_wr_en", wr_enable, 1);
        chk("t4_rel_rd", RD, 1);
        tick();
        mem_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            #1;
            chk($sformatf("t4_issue%0d_wr_en", k), wr_enable, 1);
            chk($sformatf("t4_issue%0d_rd", k), RD, 4'(k));
            tick();
        end
        chk("t4_last_rd", RD, 6);
        chk("t4_last_wd", WD, 66);
        tick();
        chk("t4_idle_wr_en", wr_enable, 0);
        chk("t4_log_len", wlog.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t4_log%0d", i), (i < wlog.size()) ? wlog[i] : '1, exp4[i]);

        // 5. two writes to the same register, last one wins
        alu_valid = 1'b1; alu_rd = 4'd3; alu_wd = 32'd2;
        #1 chk("t5_a_ready", alu_ready, 1);
        tick();
        alu_wd = 32'd7;
        #1;
        chk("t5_b_ready", alu_ready, 1);
        chk("t5_c2_pending", pending, 16'h0008);
        chk("t5_c2_wd", WD, 2);
        tick();
        alu_valid = 1'b0;
        #1;
        chk("t5_c3_pending", pending, 16'h0008);
        chk("t5_c3_wd", WD, 7);
        tick();
        chk("t5_idle_pending", pending, 0);
        chk("t5_r3", rf[3], 7);

        // 6. async reset discards buffered entries
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 4'(10 + k); alu_wd = 32'(k + 1);
            tick();
        end
        alu_valid = 1'b0;
        #1;
        chk("t6_count", fifo_count, 3);
        chk("t6_pending", pending, 16'h1C00);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_pending", pending, 0);
        chk("t6_rst_wr_en", wr_enable, 0);
        chk("t6_rst_rd", RD, 0);
        tick();
        rst = 1'b1; hold = 1'b0;
        wlog.delete();
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("t6_stale%0d_wr_en", k), wr_enable, 0);
            tick();
        end
        chk("t6_log_len", wlog.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
